wb_cmd_master: RTL and testbench

Wishbone initiator that converts single-word command requests into one Wishbone classic read or write cycle, and returns the result on a response handshake. It drives the same FPGA-side register bus that the AL4S3B register responders sit on, so on-fabric logic such as test sequencers and DMA helpers can access those registers without the AHB bridge. Each command produces one bus cycle with no pipelining. A timeout stops an unresponsive address from hanging the bus.

---
 rtl/wb_cmd_master.sv | 149 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns one command handshake into one Wishbone classic
// read or write cycle and returns the result on a response handshake.
// Single outstanding command, no pipelining; an optional timeout releases
// the bus when the addressed responder never acknowledges.
module wb_cmd_master #(
  parameter int ADDRWIDTH      = 7,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  // command side
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  input  logic [3:0]           cmd_byte_stb_i,
  // response side
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  // Wishbone initiator
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i
);

  // Counter is at least one bit wide so a disabled timeout still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   adr_q, adr_d;
  logic [DATAWIDTH-1:0]   dat_q, dat_d;
  logic [3:0]             bstb_q, bstb_d;
  logic                   we_q, we_d;
  logic                   cyc_q, cyc_d;
  logic [DATAWIDTH-1:0]   rsp_dat_q, rsp_dat_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Next-state and next-output decode; every output is taken from a flop.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    bstb_d    = bstb_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          bstb_d  = cmd_byte_stb_i;
          we_d    = cmd_we_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ACK wins over a timeout that expires in the same cycle.
        if (WBm_ACK_i) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          rsp_dat_d = we_q ? '0 : WBm_DAT_i;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else if (cnt_q != CNT_MAX) begin
          // Saturate rather than wrap when the timeout is disabled.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything, even mid-cycle.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      bstb_q    <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      bstb_q    <= bstb_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Handshake flags decode straight from the state register.
  assign cmd_ready_o    = (state_q == IDLE);
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = rsp_err_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_DAT_o      = dat_q;
  assign WBm_BYTE_STB_o = bstb_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed commands against a small register-block
// responder, with a scoreboard queue checked by an independent monitor.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [6:0]  cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_bs = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [6:0]  wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_bs;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int mode = 0;          // 0 normal, 1 never ack, 2 ack in 16th STB cycle, 3 ack one cycle too late
  int stb_run = 0;
  int last_stb_len = 0;
  logic [32:0] exp_q[$];  // {err, data}

  wb_cmd_master #(.ADDRWIDTH(7), .DATAWIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_byte_stb_i(cmd_bs),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .WBm_ADR_o(wb_adr), .WBm_DAT_o(wb_dat_o), .WBm_BYTE_STB_o(wb_bs),
    .WBm_CYC_o(wb_cyc), .WBm_STB_o(wb_stb), .WBm_WE_o(wb_we),
    .WBm_DAT_i(wb_dat_i), .WBm_ACK_i(wb_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // Register-block responder: ID at 0x00, GPIO_OUT at 0x03, scratch at 0x05.
  logic [31:0] scratch;
  logic [7:0]  gpio_out;
  int          stb_seen;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_dat_i <= '0;
      scratch  <= 32'hABCD0000;
      gpio_out <= 8'h00;
      stb_seen <= 0;
    end else begin
      stb_seen <= (wb_stb && !wb_ack) ? stb_seen + 1 : 0;
      wb_ack   <= 1'b0;
      if (wb_cyc && wb_stb && !wb_ack &&
          (mode == 0 || (mode == 2 && stb_seen == 14) || (mode == 3 && stb_seen == 15))) begin
        wb_ack <= 1'b1;
        case (wb_adr)
          7'h00:   wb_dat_i <= 32'h0055C332;
          7'h03:   wb_dat_i <= {24'h0, gpio_out};
          7'h05:   wb_dat_i <= scratch;
          default: wb_dat_i <= 32'hFABDEFAC;
        endcase
        if (wb_we) begin
          if (wb_adr == 7'h03 && wb_bs[0]) gpio_out <= wb_dat_o[7:0];
          if (wb_adr == 7'h05) begin
            for (int b = 0; b < 4; b++)
              if (wb_bs[b]) scratch[8*b +: 8] <= wb_dat_o[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Length of the most recent STB pulse, in cycles.
  always @(negedge clk) begin
    if (rst) stb_run = 0;
    else if (wb_stb) stb_run++;
    else if (stb_run != 0) begin
      last_stb_len = stb_run;
      stb_run = 0;
    end
  end

  // Monitor: every consumed response is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got dat=0x%08h err=%0b expected none", rsp_dat, rsp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_dat", rsp_dat, e[31:0]);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
        $display("rsp: dat=0x%08h err=%0b", rsp_dat, rsp_err);
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                          input logic [3:0] bs, input logic [31:0] edat, input logic eerr,
                          output int acc);
    bit ok;
    @(posedge clk); #1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_bs = bs; cmd_valid = 1'b1;
    exp_q.push_back({eerr, edat});
    ok = 0; acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; acc = cyc_cnt; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("cmd: we=%0b adr=0x%02h dat=0x%08h bs=0x%h", we, adr, dat, bs);
    if (!ok) begin
      void'(exp_q.pop_back());
      checks++; failures++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic wait_valid(input int acc, input bit chk_lat);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL rsp_valid_timeout: got no rsp_valid expected one within 60 cycles");
    end else if (chk_lat) chk("rsp_latency", cyc_cnt - acc, 3);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) return;
    end
    checks++; failures++;
    $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
  endtask

  int acc;
  int accs[3];
  int n;
  logic [6:0]  b2b_adr[3] = '{7'h00, 7'h7F, 7'h05};
  logic [31:0] b2b_exp[3] = '{32'h0055C332, 32'hFABDEFAC, 32'hABCDBEEF};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'h0, wb_cyc}, 0);
    chk("rst_stb", {31'h0, wb_stb}, 0);
    chk("rst_we", {31'h0, wb_we}, 0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
    chk("rst_adr", {25'h0, wb_adr}, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_bstb", {28'h0, wb_bs}, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", {31'h0, cmd_ready}, 1);

    // Read ID register: two-cycle strobe, response at accept+3
    send_cmd(0, 7'h00, 0, 4'hF, 32'h0055C332, 0, acc);
    wait_valid(acc, 1);
    wait_drain();
    chk("stb_len_read", last_stb_len, 2);

    // Partial write then read-back of scratch
    send_cmd(1, 7'h05, 32'h0000BEEF, 4'h3, 32'h0, 0, acc);
    wait_valid(acc, 1);
    wait_drain();
    chk("we_idle", {31'h0, wb_we}, 0);
    send_cmd(0, 7'h05, 0, 4'hF, 32'hABCDBEEF, 0, acc);
    wait_drain();

    // GPIO_OUT write and read-back
    send_cmd(1, 7'h03, 32'h000000A5, 4'h1, 32'h0, 0, acc);
    wait_drain();
    send_cmd(0, 7'h03, 0, 4'hF, 32'h000000A5, 0, acc);
    wait_drain();
    chk("gpio_out", {24'h0, gpio_out}, 32'hA5);
    chk("adr_held_idle", {25'h0, wb_adr}, 32'h03);

    // Unmapped address
    send_cmd(0, 7'h7F, 0, 4'hF, 32'hFABDEFAC, 0, acc);
    wait_drain();

    // Back-to-back with cmd_valid held high
    @(posedge clk); #1;
    cmd_we = 0; cmd_bs = 4'hF; cmd_adr = b2b_adr[0]; cmd_valid = 1'b1;
    exp_q.push_back({1'b0, b2b_exp[0]});
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accs[n] = cyc_cnt;
        n++;
        @(posedge clk); #1;
        if (n < 3) begin
          cmd_adr = b2b_adr[n];
          exp_q.push_back({1'b0, b2b_exp[n]});
        end else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", n, 3);
    chk("b2b_gap1", accs[1] - accs[0], 4);
    chk("b2b_gap2", accs[2] - accs[1], 4);
    wait_drain();

    // Timeout: responder never acks
    mode = 1;
    send_cmd(0, 7'h10, 0, 4'hF, 32'h0, 1, acc);
    wait_drain();
    chk("stb_len_timeout", last_stb_len, 16);

    // ACK in the 16th strobe cycle wins over the timeout
    mode = 2;
    send_cmd(0, 7'h00, 0, 4'hF, 32'h0055C332, 0, acc);
    wait_drain();
    chk("stb_len_late_ack", last_stb_len, 16);

    // ACK one cycle after the timeout lands in RESP and is ignored
    mode = 3;
    send_cmd(0, 7'h00, 0, 4'hF, 32'h0, 1, acc);
    wait_drain();
    chk("stb_len_too_late", last_stb_len, 16);

    // Asynchronous reset while in BUS
    mode = 1;
    send_cmd(0, 7'h20, 0, 4'hF, 32'h0, 0, acc);
    @(negedge clk);
    chk("bus_stb_before_rst", {31'h0, wb_stb}, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cyc", {31'h0, wb_cyc}, 0);
    chk("async_rst_stb", {31'h0, wb_stb}, 0);
    chk("async_rst_rsp_valid", {31'h0, rsp_valid}, 0);
    chk("async_rst_adr", {25'h0, wb_adr}, 0);
    exp_q.delete();
    mode = 0;
    @(posedge clk); #1 rst = 1'b0;
    send_cmd(0, 7'h00, 0, 4'hF, 32'h0055C332, 0, acc);
    wait_valid(acc, 1);
    wait_drain();

    // Response held off for 5 cycles
    rsp_ready = 1'b0;
    send_cmd(0, 7'h7F, 0, 4'hF, 32'hFABDEFAC, 0, acc);
    wait_valid(acc, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'h0, rsp_valid}, 1);
      chk("hold_rsp_dat", rsp_dat, 32'hFABDEFAC);
      chk("hold_cmd_ready", {31'h0, cmd_ready}, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("final_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
